// File: rtl/act_result_writer_if.sv
// Write port between the result writer and the output buffer.
//
// Handshake: a beat transfers on every rising edge where wr_valid && wr_ready.
// While wr_valid is high and wr_ready is low, wr_addr, wr_data and wr_strb are
// held stable, and wr_valid never drops without a transfer. wr_ready may be
// driven freely by the sink and is never required to wait for wr_valid.
interface act_result_writer_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;

  modport master (output wr_valid, output wr_addr, output wr_data, output wr_strb,
                  input  wr_ready);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_data, input  wr_strb,
                  output wr_ready);
endinterface

// File: rtl/act_result_writer.sv
// Write-back stage: packs pairs of 16-bit activated results into 32-bit beats,
// queues them in a small FIFO and writes them out at byte addresses counted
// from a programmed base. The input stream cannot be stalled, so a beat that
// finds the FIFO full (with no pop in the same cycle) is dropped, its address
// slot is skipped, and the sticky overflow flag is raised.
module act_result_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           num_results,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  act_result_writer_if.master   wr,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [1:0]            state_dbg
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [15:0]           num_q;
  logic [15:0]           acc_cnt;   // samples accepted so far in this job
  logic [15:0]           beat_idx;  // push attempts so far, dropped ones included
  logic [DATA_WIDTH-1:0] pack_lo;   // even-position sample waiting for its partner

  // Beat FIFO storage; the head entry drives the write port directly.
  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [31:0]           mem_data [FIFO_DEPTH];
  logic [3:0]            mem_strb [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic                  take;
  logic                  last;
  logic                  push;
  logic                  push_ok;
  logic                  pop;
  logic                  fifo_empty_next;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [31:0]           push_data;
  logic [3:0]            push_strb;

  // Sample acceptance, beat formation and FIFO push/pop decisions.
  always_comb begin
    take      = (state == S_RUN) && in_valid && (acc_cnt < num_q);
    last      = take && ((17'(acc_cnt) + 17'd1) == 17'(num_q));
    // An odd-position sample completes a beat; an even-position last sample
    // is flushed out alone as a half beat.
    push      = take && (acc_cnt[0] || last);
    push_data = acc_cnt[0] ? 32'({in_data, pack_lo}) : 32'(in_data);
    push_strb = acc_cnt[0] ? 4'hF : 4'h3;
    push_addr = base_q + (ADDR_WIDTH'(beat_idx) << 2);
    pop       = (count != '0) && wr.wr_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    push_ok   = push && ((count != CW'(FIFO_DEPTH)) || pop);
    fifo_empty_next = (count == '0) || ((count == CW'(1)) && pop && !push_ok);
  end

  // Write port outputs read the registered FIFO head; zero when nothing is queued.
  assign wr.wr_valid = (count != '0);
  assign wr.wr_addr  = wr.wr_valid ? mem_addr[rd_ptr] : '0;
  assign wr.wr_data  = wr.wr_valid ? mem_data[rd_ptr] : '0;
  assign wr.wr_strb  = wr.wr_valid ? mem_strb[rd_ptr] : '0;
  assign state_dbg   = state;

  // FIFO storage write; contents need no reset because count gates the outputs.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
      mem_strb[wr_ptr] <= push_strb;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Job control FSM with registered busy/done/overflow and sample packing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      base_q   <= '0;
      num_q    <= '0;
      acc_cnt  <= '0;
      beat_idx <= '0;
      pack_lo  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (push && !push_ok) overflow <= 1'b1;
      if (take) begin
        acc_cnt <= acc_cnt + 16'd1;
        if (!acc_cnt[0]) pack_lo <= in_data;
      end
      // The index advances on dropped beats too, so their address slot is skipped.
      if (push) beat_idx <= beat_idx + 16'd1;

      case (state)
        S_IDLE: begin
          if (start) begin
            overflow <= 1'b0;
            if (num_results != 16'd0) begin
              base_q   <= base_addr;
              num_q    <= num_results;
              acc_cnt  <= '0;
              beat_idx <= '0;
              pack_lo  <= '0;
              busy     <= 1'b1;
              state    <= S_RUN;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (last) state <= S_FLUSH;
        end
        S_FLUSH: begin
          // Finish on the edge that pops the final beat so done follows it directly.
          if (fifo_empty_next) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_act_result_writer.sv
// Bench for act_result_writer: a table of single-job vectors with hand-computed
// beats, followed by hand-written sequences for stall, overflow, empty job and
// mid-job reset. Beats are checked against an expected queue as they transfer.
module tb_act_result_writer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] num_results;
  logic [15:0] in_data;
  logic        in_valid;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [1:0]  state_dbg;

  act_result_writer_if #(.ADDR_WIDTH(16)) wr_if ();

  act_result_writer #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16),
    .FIFO_DEPTH(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .num_results (num_results),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .wr          (wr_if.master),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [51:0] exp_q[$];     // {addr, data, strb}
  int          xfer_q[$];    // cycle stamps of observed transfers
  int          last_xfer = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // A transfer seen at this negedge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && wr_if.wr_valid && wr_if.wr_ready) begin
      logic [51:0] act;
      logic [51:0] exp;
      act = {wr_if.wr_addr, wr_if.wr_data, wr_if.wr_strb};
      xfer_q.push_back(cyc);
      last_xfer = cyc;
      check("beat_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check("beat", 64'(act), 64'(exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [15:0] b, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_results = n;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 16'hDEAD; num_results = 16'h00FF;
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 16'h0;
  endtask

  // Waits for done within a cycle budget, checks its timing against the last
  // transfer (when beats were expected) and that it lasts one cycle.
  task automatic wait_done(input bit check_timing);
    int dcyc;
    dcyc = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    check("done_seen", 64'(dcyc >= 0), 64'd1);
    if (dcyc >= 0) begin
      check("busy_at_done", 64'(busy), 64'd0);
      if (check_timing) check("done_after_last_xfer", 64'(dcyc), 64'(last_xfer + 1));
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0]       base;
    logic [15:0]       n;
    int                n_in;
    logic [4:0][15:0]  d;      // d[0] is sent first (literal lists it last)
    int                n_exp;
    logic [1:0][51:0]  exp;    // exp[0] is the first beat (literal lists it last)
  } vec_t;

  vec_t vecs[5];

  initial begin
    start = 1'b0; base_addr = '0; num_results = '0;
    in_data = '0; in_valid = 1'b0; wr_if.wr_ready = 1'b0;
    rst_n = 1'b0;

    vecs[0] = '{base:16'h0100, n:16'd4, n_in:4,
                d:{16'h0, 16'h4444, 16'h3333, 16'h2222, 16'h1111}, n_exp:2,
                exp:{{16'h0104, 32'h44443333, 4'hF}, {16'h0100, 32'h22221111, 4'hF}}};
    vecs[1] = '{base:16'h0200, n:16'd3, n_in:4,
                d:{16'h0, 16'h5555, 16'h3333, 16'h2222, 16'h1111}, n_exp:2,
                exp:{{16'h0204, 32'h00003333, 4'h3}, {16'h0200, 32'h22221111, 4'hF}}};
    vecs[2] = '{base:16'hFFFC, n:16'd4, n_in:4,
                d:{16'h0, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, n_exp:2,
                exp:{{16'h0000, 32'hDDDDCCCC, 4'hF}, {16'hFFFC, 32'hBBBBAAAA, 4'hF}}};
    vecs[3] = '{base:16'h0010, n:16'd1, n_in:2,
                d:{16'h0, 16'h0, 16'h0, 16'h6666, 16'h7777}, n_exp:1,
                exp:{52'h0, {16'h0010, 32'h00007777, 4'h3}}};
    vecs[4] = '{base:16'h0300, n:16'd2, n_in:2,
                d:{16'h0, 16'h0, 16'h0, 16'h8000, 16'h0001}, n_exp:1,
                exp:{52'h0, {16'h0300, 32'h80000001, 4'hF}}};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data, wr_if.wr_strb,
               busy, done, overflow, state_dbg}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single jobs with the sink always ready
    wr_if.wr_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      xfer_q.delete();
      for (int b = 0; b < vecs[v].n_exp; b++) exp_q.push_back(vecs[v].exp[b]);
      do_start(vecs[v].base, vecs[v].n);
      check("busy_after_start", 64'(busy), 64'd1);
      for (int i = 0; i < vecs[v].n_in; i++) send(vecs[v].d[i]);
      wait_done(1'b1);
      check("beats_transferred", 64'(xfer_q.size()), 64'(vecs[v].n_exp));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("no_overflow", 64'(overflow), 64'd0);
    end

    // Stall: sink not ready for 10 cycles, head beat must hold steady
    begin
      int gap;
      wr_if.wr_ready = 1'b0;
      xfer_q.delete();
      exp_q.push_back({16'h0400, 32'hA002A001, 4'hF});
      exp_q.push_back({16'h0404, 32'hA004A003, 4'hF});
      do_start(16'h0400, 16'd4);
      send(16'hA001); send(16'hA002); send(16'hA003); send(16'hA004);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        check("stall_head",
              64'({wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data, wr_if.wr_strb}),
              64'({1'b1, 16'h0400, 32'hA002A001, 4'hF}));
      end
      @(posedge clk); #1;
      wr_if.wr_ready = 1'b1;
      wait_done(1'b1);
      gap = (xfer_q.size() == 2) ? (xfer_q[1] - xfer_q[0]) : -1;
      check("stall_release_back_to_back", 64'(gap), 64'd1);
      check("stall_queue_drained", 64'(exp_q.size()), 64'd0);
    end

    // Overflow: 20 results into an 8-deep FIFO with the sink stalled
    wr_if.wr_ready = 1'b0;
    xfer_q.delete();
    for (int k = 0; k < 8; k++)
      exp_q.push_back({16'(4 * k), 16'(2 * k + 2), 16'(2 * k + 1), 4'hF});
    do_start(16'h0000, 16'd20);
    for (int i = 0; i < 20; i++) begin
      send(16'(i + 1));
      // The 9th beat completes with sample index 17 and is the first drop.
      check("overflow_timing", 64'(overflow), 64'(i >= 17));
    end
    @(posedge clk); #1;
    wr_if.wr_ready = 1'b1;
    wait_done(1'b1);
    check("overflow_beats", 64'(xfer_q.size()), 64'd8);
    check("overflow_queue_drained", 64'(exp_q.size()), 64'd0);
    check("overflow_sticky", 64'(overflow), 64'd1);
    exp_q.push_back({16'h0050, 32'h0B0B0A0A, 4'hF});
    do_start(16'h0050, 16'd2);
    check("overflow_cleared_by_start", 64'(overflow), 64'd0);
    send(16'h0A0A); send(16'h0B0B);
    wait_done(1'b1);
    check("after_overflow_drained", 64'(exp_q.size()), 64'd0);

    // Empty job: done on the cycle after start, nothing written, never busy
    do_start(16'h0900, 16'd0);
    check("n0_done", 64'({done, busy, wr_if.wr_valid}), 64'(3'b100));
    @(posedge clk); #1;
    check("n0_after", 64'({done, busy, wr_if.wr_valid, state_dbg}), 64'd0);

    // Reset in the middle of a job with one beat queued but not taken
    wr_if.wr_ready = 1'b0;
    do_start(16'h0600, 16'd4);
    send(16'h1234); send(16'h5678); send(16'h9ABC);
    check("pre_reset_valid", 64'(wr_if.wr_valid), 64'd1);
    rst_n = 1'b0;
    #2;
    check("mid_reset_outputs",
          64'({wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data, wr_if.wr_strb,
               busy, done, overflow, state_dbg}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_if.wr_ready = 1'b1;
    xfer_q.delete();
    exp_q.push_back({16'h0700, 32'hCAFEBEEF, 4'hF});
    do_start(16'h0700, 16'd2);
    send(16'hBEEF); send(16'hCAFE);
    wait_done(1'b1);
    check("post_reset_beats", 64'(xfer_q.size()), 64'd1);
    check("post_reset_drained", 64'(exp_q.size()), 64'd0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/act_result_writer.md
# act_result_writer

Write-back stage that receives the 16-bit activated result stream from the activation stage and writes it to the output buffer. It packs two results per 32-bit beat, buffers beats in a small FIFO, and drives a write port with a valid/ready handshake and byte addresses counted from a programmed base. The upstream stream has no backpressure, so FIFO overflow is detected and reported rather than stalled.

## Interface
- DATA_WIDTH, 16, width of one result; fixed pack factor of 2 per beat.
- ADDR_WIDTH, 16, byte-address width of the write port.
- FIFO_DEPTH, 8, beat FIFO entries; power of two, ≥2.

- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse; launches a job when idle
- base_addr  input  ADDR_WIDTH  byte address of first beat; sampled with start
- num_results  input  16  results in the job; sampled with start
- in_data  input  DATA_WIDTH  activated result
- in_valid  input  1  in_data valid this cycle; no ready
- wr_valid  output  1  beat available on write port
- wr_ready  input  1  sink accepts beat
- wr_addr  output  ADDR_WIDTH  byte address of beat
- wr_data  output  32  packed beat; first result in [15:0], second in [31:16]
- wr_strb  output  4  byte enables
- busy  output  1  job in progress
- done  output  1  one-cycle job-complete pulse
- overflow  output  1  sticky; a beat was dropped in the current or last job

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: in_valid ignored. start with num_results≠0 → latch base_addr, num_results; clear overflow, pack, and counters; → RUN. start with num_results=0 → clear overflow; → DONE.
- RUN: each in_valid sample is accepted until num_results samples have been accepted. Samples beyond that are ignored. An even-position sample goes to the low half of the pack register. An odd-position sample completes the beat. Completed beat is pushed with strb 4'hF. If the last sample is even-position (num_results odd), it is pushed immediately with wr_data[31:16]=0 and strb 4'h3. Once the last sample is pushed → FLUSH.
- Each pushed entry carries addr = base + 4·beat_index. beat_index increments on every push attempt, including dropped ones. Total beats = ceil(num_results/2).
- FIFO: push and pop in the same cycle are always legal, including when the FIFO is full. A push when full without a simultaneous pop is dropped. The dropped beat's address is skipped and overflow is set (sticky until the next accepted start).
- FLUSH: drain the FIFO. When the FIFO is empty and all beats have been pushed or dropped → DONE.
- DONE: done=1 for one cycle → IDLE.
- start while not in IDLE is ignored.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset values: wr_valid=0, wr_addr=0, wr_data=0, wr_strb=0, busy=0, done=0, overflow=0. Reset mid-job aborts the job, empties the FIFO, and returns to IDLE; no partial beat is emitted.
- busy=1 from the edge that accepts start until the edge that enters DONE. busy=0 while done=1.
- Samples are captured on the rising edge where in_valid=1. Back-to-back samples are accepted every cycle.
- Latency: a beat completed at edge k with the FIFO empty gives wr_valid=1 in cycle k+1 (registered FIFO head).
- Write handshake: a beat transfers on an edge with wr_valid&wr_ready. While wr_valid&!wr_ready, wr_addr, wr_data, and wr_strb are held stable. wr_valid never drops without a transfer. Beats leave in push order, one per cycle at most.
- done asserts in the cycle after the final beat transfers. For num_results=0, done asserts in the cycle after start.
- overflow updates in the cycle after the dropped push.

## Test plan
- base=0x0100, N=4, inputs 0x1111,0x2222,0x3333,0x4444 back-to-back, wr_ready=1 → beat (0x0100, 0x22221111, F), then beat (0x0104, 0x44443333, F); done 1 cycle after the second transfer; overflow=0.
- base=0x0200, N=3, inputs 0x1111,0x2222,0x3333 → (0x0200, 0x22221111, F), (0x0204, 0x00003333, 3); a 4th in_valid sample is ignored.
- N=4 with wr_ready=0 for 10 cycles → wr_valid held, first beat fields stable throughout; on release both beats transfer in order on consecutive cycles; then done.
- FIFO_DEPTH=8, wr_ready=0, base=0, N=20 → 9th and 10th beats dropped, overflow=1. After release, 8 beats at addresses 0x0000..0x001C, then done. A next start with N=2 clears overflow.
- N=0 start → done the next cycle; wr_valid stays 0; busy stays 0.
- rst_n low mid-RUN after 3 samples → all outputs return to reset values; a new start with N=2 produces a single correct beat at the new base.
